// File: rtl/mips_top.sv
// Five-stage pipelined MIPS core (ID-stage forwarding, load-use stall, beq resolved in EX)
// plus a unified word-organised RAM with combinational reads and a clocked write.
package mips_pkg;
    typedef enum logic [2:0] {
        ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2,
        ALU_OR  = 3'd3, ALU_SLT = 3'd4, ALU_INC = 3'd5
    } aluop_t;

    typedef struct packed {
        logic [31:0] rega;
        logic [31:0] regb;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic [4:0]  dest;
        aluop_t      aluop;
        logic        alusrc;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        branch;
    } idex_t;
endpackage

module mips_execute
    import mips_pkg::*;
(
    input  logic [31:0] id_ex_rega,
    input  logic [31:0] id_ex_regb,
    input  logic [31:0] id_ex_imm,
    input  logic        id_ex_alusrc,
    input  aluop_t      id_ex_aluop,
    output logic [31:0] aluout
);
    logic [31:0] mux_imregb;

    always_comb begin
        if (id_ex_aluop == ALU_INC)
            mux_imregb = 32'd1;
        else if (id_ex_alusrc)
            mux_imregb = id_ex_imm;
        else
            mux_imregb = id_ex_regb;
        case (id_ex_aluop)
            ALU_SUB: aluout = id_ex_rega - mux_imregb;
            ALU_AND: aluout = id_ex_rega & mux_imregb;
            ALU_OR:  aluout = id_ex_rega | mux_imregb;
            ALU_SLT: aluout = {31'd0, $signed(id_ex_rega) < $signed(mux_imregb)};
            default: aluout = id_ex_rega + mux_imregb;
        endcase
    end
endmodule

module mips_core
    import mips_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic        dmem_rd,
    output logic        dmem_wr,
    input  logic [31:0] dmem_rdata
);
    logic [31:0] pc, if_id_instr, if_id_pc4;
    logic [31:0] regs [0:31];
    idex_t       id_ex, dec;
    logic [31:0] aluout, opa, opb, mem_result, branch_target;
    logic [31:0] ex_mem_aluout, ex_mem_regb, mem_wb_data;
    logic [4:0]  ex_mem_dest, mem_wb_dest, rs, rt;
    logic        ex_mem_regwrite, ex_mem_memread, ex_mem_memwrite, mem_wb_regwrite;
    logic        stall, taken;

    assign rs            = if_id_instr[25:21];
    assign rt            = if_id_instr[20:16];
    assign mem_result    = ex_mem_memread ? dmem_rdata : ex_mem_aluout;
    assign taken         = id_ex.branch && (id_ex.rega == id_ex.regb);
    assign branch_target = id_ex.pc4 + {id_ex.imm[29:0], 2'b00};
    assign stall         = id_ex.memread && (id_ex.dest != 5'd0) &&
                           ((id_ex.dest == rs) || (id_ex.dest == rt));

    // Operands are forwarded at decode so the ID/EX register always holds the true values.
    function automatic logic [31:0] fwd(input logic [4:0] idx);
        if (idx == 5'd0)                               return '0;
        if (id_ex.regwrite && id_ex.dest == idx)       return aluout;
        if (ex_mem_regwrite && ex_mem_dest == idx)     return mem_result;
        if (mem_wb_regwrite && mem_wb_dest == idx)     return mem_wb_data;
        return regs[idx];
    endfunction

    always_comb begin
        opa = fwd(rs);
        opb = fwd(rt);
    end

    always_comb begin
        dec       = '0;
        dec.rega  = opa;
        dec.regb  = opb;
        dec.imm   = {{16{if_id_instr[15]}}, if_id_instr[15:0]};
        dec.pc4   = if_id_pc4;
        dec.dest  = if_id_instr[15:11];
        dec.aluop = ALU_ADD;
        case (if_id_instr[31:26])
            6'h00: case (if_id_instr[5:0])
                6'h20: dec.regwrite = 1'b1;
                6'h22: begin dec.aluop = ALU_SUB; dec.regwrite = 1'b1; end
                6'h24: begin dec.aluop = ALU_AND; dec.regwrite = 1'b1; end
                6'h25: begin dec.aluop = ALU_OR;  dec.regwrite = 1'b1; end
                6'h2a: begin dec.aluop = ALU_SLT; dec.regwrite = 1'b1; end
                6'h28: begin dec.aluop = ALU_INC; dec.regwrite = 1'b1; end
                default: ;
            endcase
            6'h08: begin dec.alusrc = 1'b1; dec.regwrite = 1'b1; dec.dest = rt; end
            6'h23: begin
                dec.alusrc = 1'b1; dec.regwrite = 1'b1; dec.memread = 1'b1; dec.dest = rt;
            end
            6'h2b: begin dec.alusrc = 1'b1; dec.memwrite = 1'b1; end
            6'h04: begin dec.aluop = ALU_SUB; dec.branch = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc          <= '0;
            if_id_instr <= '0;
            if_id_pc4   <= '0;
        end else if (taken) begin
            pc          <= branch_target;
            if_id_instr <= '0;
        end else if (!stall) begin
            pc          <= pc + 32'd4;
            if_id_instr <= imem_data;
            if_id_pc4   <= pc + 32'd4;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            id_ex <= '0;
        else if (taken || stall)
            id_ex <= '0;
        else
            id_ex <= dec;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ex_mem_aluout   <= '0;
            ex_mem_regb     <= '0;
            ex_mem_dest     <= '0;
            ex_mem_regwrite <= 1'b0;
            ex_mem_memread  <= 1'b0;
            ex_mem_memwrite <= 1'b0;
            mem_wb_data     <= '0;
            mem_wb_dest     <= '0;
            mem_wb_regwrite <= 1'b0;
        end else begin
            ex_mem_aluout   <= aluout;
            ex_mem_regb     <= id_ex.regb;
            ex_mem_dest     <= id_ex.dest;
            ex_mem_regwrite <= id_ex.regwrite;
            ex_mem_memread  <= id_ex.memread;
            ex_mem_memwrite <= id_ex.memwrite;
            mem_wb_data     <= mem_result;
            mem_wb_dest     <= ex_mem_dest;
            mem_wb_regwrite <= ex_mem_regwrite;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 32; i++)
                regs[i] <= '0;
            regs[16] <= 32'd13;
            regs[17] <= 32'd7;
        end else if (mem_wb_regwrite && mem_wb_dest != 5'd0) begin
            regs[mem_wb_dest] <= mem_wb_data;
        end
    end

    mips_execute EXECUTE (
        .id_ex_rega   (id_ex.rega),
        .id_ex_regb   (id_ex.regb),
        .id_ex_imm    (id_ex.imm),
        .id_ex_alusrc (id_ex.alusrc),
        .id_ex_aluop  (id_ex.aluop),
        .aluout       (aluout)
    );

    assign imem_addr  = pc;
    assign dmem_addr  = ex_mem_aluout;
    assign dmem_wdata = ex_mem_regb;
    assign dmem_rd    = ex_mem_memread;
    assign dmem_wr    = ex_mem_memwrite;
endmodule

module mips_ram #(
    parameter int MEM_WORDS = 1024,
    parameter int DATA_W    = 32,
    parameter     INIT_FILE = ""
) (
    input  logic              clock,
    input  logic [31:0]       imem_addr,
    output logic [DATA_W-1:0] imem_data,
    input  logic [31:0]       dmem_addr,
    input  logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_rd,
    input  logic              dmem_wr,
    output logic [DATA_W-1:0] dmem_rdata
);
    localparam int AW = $clog2(MEM_WORDS);

    logic [DATA_W-1:0] memory [0:MEM_WORDS-1];
    logic              unused_bits;

    // Upper address bits wrap, byte offset is ignored, and reads never depend on dmem_rd.
    assign unused_bits = ^{imem_addr[31:AW+2], imem_addr[1:0],
                           dmem_addr[31:AW+2], dmem_addr[1:0], dmem_rd};

    assign imem_data  = memory[imem_addr[AW+1:2]];
    assign dmem_rdata = memory[dmem_addr[AW+1:2]];

    always_ff @(posedge clock) begin
        if (dmem_wr)
            memory[dmem_addr[AW+1:2]] <= dmem_wdata;
    end
endmodule

module mips_top #(
    parameter int MEM_WORDS = 1024,
    parameter int DATA_W    = 32,
    parameter     INIT_FILE = ""
) (
    input logic clock,
    input logic reset
);
    logic [31:0] imem_addr, imem_data, dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_rd, dmem_wr;

    mips_core MIPS (
        .clock      (clock),
        .reset      (reset),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rd    (dmem_rd),
        .dmem_wr    (dmem_wr),
        .dmem_rdata (dmem_rdata)
    );

    mips_ram #(
        .MEM_WORDS (MEM_WORDS),
        .DATA_W    (DATA_W),
        .INIT_FILE (INIT_FILE)
    ) RAM (
        .clock      (clock),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rd    (dmem_rd),
        .dmem_wr    (dmem_wr && !reset),
        .dmem_rdata (dmem_rdata)
    );
endmodule

// File: tb/tb_mips_top.sv
// Directed bench for mips_top: INC program, store/load, address wrap,
// same-cycle read/write, reset mid-run and reset-preserve reruns.
module tb_mips_top;
    localparam int WORDS = 1024;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    logic [31:0] image   [0:WORDS-1];
    logic [31:0] exp_img [0:WORDS-1];

    mips_top #(.MEM_WORDS(WORDS), .DATA_W(32), .INIT_FILE("")) dut (
        .clock (clock),
        .reset (reset)
    );

    always #3 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic load_image();
        for (int i = 0; i < WORDS; i++)
            dut.RAM.memory[i] = image[i];
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic check_final(input string run);
        int bad;
        bad = 0;
        check({run, "_s3"},   dut.MIPS.regs[19], 32'd23);
        check({run, "_t0"},   dut.MIPS.regs[8],  32'h5A5A5A5A);
        check({run, "_t1"},   dut.MIPS.regs[9],  32'h5A5A5A5A);
        check({run, "_m16"},  dut.RAM.memory[16], 32'h5A5A5A5A);
        check({run, "_wrap"}, dut.RAM.memory[2],  32'd13);
        for (int i = 0; i < WORDS; i++)
            if (dut.RAM.memory[i] !== exp_img[i]) bad++;
        check({run, "_image"}, bad, 32'd0);
    endtask

    initial begin
        bit found;

        for (int i = 0; i < WORDS; i++) image[i] = '0;
        image[0]  = 32'h10000002; // beq $0,$0,+2 (skip data words 1,2)
        image[3]  = 32'h02119820; // add $s3,$s0,$s1
        image[4]  = 32'h02609828; // inc $s3
        image[5]  = 32'h02609828; // inc $s3
        image[6]  = 32'h02609828; // inc $s3
        image[7]  = 32'h8C080080; // lw  $t0,0x80($0)
        image[8]  = 32'hAC080040; // sw  $t0,0x40($0)
        image[9]  = 32'h8C090040; // lw  $t1,0x40($0)
        image[10] = 32'hAC101008; // sw  $s0,0x1008($0)  wraps to word 2
        image[11] = 32'h1000FFFF; // beq $0,$0,-1  halt loop
        image[16] = 32'h11111111;
        image[32] = 32'h5A5A5A5A;
        for (int i = 0; i < WORDS; i++) exp_img[i] = image[i];
        exp_img[2]  = 32'd13;
        exp_img[16] = 32'h5A5A5A5A;

        // Run 1: fresh image
        load_image();
        @(negedge clock);
        check("rst_pc", dut.MIPS.pc, 32'd0);
        check("rst_s0", dut.MIPS.regs[16], 32'd13);
        check("rst_s1", dut.MIPS.regs[17], 32'd7);
        check("rst_wr", {31'd0, dut.dmem_wr}, 32'd0);
        reset = 1'b0;

        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clock);
            if (dut.MIPS.EXECUTE.aluout == 32'd20) found = 1'b1;
        end
        check("alu_add_seen", {31'd0, found}, 32'd1);
        check("alu_add_a", dut.MIPS.EXECUTE.id_ex_rega, 32'd13);
        check("alu_add_b", dut.MIPS.EXECUTE.mux_imregb, 32'd7);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check($sformatf("alu_inc%0d_a", k), dut.MIPS.EXECUTE.id_ex_rega, 32'd20 + k);
            check($sformatf("alu_inc%0d_b", k), dut.MIPS.EXECUTE.mux_imregb, 32'd1);
            check($sformatf("alu_inc%0d_y", k), dut.MIPS.EXECUTE.aluout, 32'd21 + k);
            check($sformatf("alu_inc%0d_op", k), {29'd0, dut.MIPS.EXECUTE.id_ex_aluop}, 32'd5);
        end

        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clock);
            if (dut.dmem_wr) found = 1'b1;
        end
        check("sw_seen", {31'd0, found}, 32'd1);
        check("sw_addr", dut.dmem_addr, 32'h40);
        check("rw_same_old", dut.dmem_rdata, 32'h11111111);
        @(negedge clock);
        check("rw_next_mem", dut.RAM.memory[16], 32'h5A5A5A5A);
        check("rw_next_rd", dut.dmem_rdata, 32'h5A5A5A5A);

        repeat (30) @(negedge clock);
        check_final("run1");

        // Run 2: reset only, RAM keeps its contents
        pulse_reset();
        repeat (40) @(negedge clock);
        check_final("rerun");

        // Run 3: reset lands while the first sw is in MEM
        load_image();
        pulse_reset();
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clock);
            if (dut.dmem_wr) found = 1'b1;
        end
        check("mid_sw_seen", {31'd0, found}, 32'd1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("mid_mem16", dut.RAM.memory[16], 32'h11111111);
        check("mid_pc", dut.MIPS.pc, 32'd0);
        check("mid_wrap", dut.RAM.memory[2], 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        check_final("midrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
